// File: rtl/axi_adf4030_pkg.sv
// rtl/axi_adf4030_pkg.sv - shared types and constants for the ADF4030 trigger channel
//
// Purpose: trigger FSM state encoding (shared with the regmap trig_state decode),
//          BSYNC phase counter width and a period helper.
// Ports:   none (package).
package axi_adf4030_pkg;

  localparam int TRIG_STATE_W = 3;
  localparam int CNT_W        = 17;

  typedef enum logic [TRIG_STATE_W-1:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    WAIT_PHASE = 3'd2,
    FIRE       = 3'd3,
    DONE       = 3'd4
  } trig_state_t;

  // BSYNC period in clk cycles: two half-periods.
  function automatic logic [CNT_W-1:0] bsync_period(input logic [15:0] ratio);
    return {ratio, 1'b0};
  endfunction

endpackage

// File: rtl/axi_adf4030_bsync_phase_cnt.sv
// rtl/axi_adf4030_bsync_phase_cnt.sv - BSYNC-aligned phase counter with misalignment flag
//
// Purpose: free-running counter over one BSYNC period, re-zeroed on every captured
//          BSYNC edge, plus a sticky flag for edges that land off-period.
// Ports:
//   clk               in   core clock
//   rstn              in   asynchronous active-low reset
//   bsync_ratio       in   BSYNC half-period in clk cycles (0 holds the counter)
//   bsync_captured    in   1-cycle pulse per captured BSYNC edge
//   misalign_check_en in   enable for the misalignment check; low clears the flag
//   cnt               out  current position in the BSYNC period
//   misalign_err      out  sticky misalignment flag
module axi_adf4030_bsync_phase_cnt
  import axi_adf4030_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      bsync_ratio,
  input  logic             bsync_captured,
  input  logic             misalign_check_en,
  output logic [CNT_W-1:0] cnt,
  output logic             misalign_err
);

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_last;
  logic             at_wrap;
  logic             locked;

  assign period      = bsync_period(bsync_ratio);
  assign period_last = period - 17'd1;
  assign at_wrap     = (cnt == period_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (bsync_captured) begin
      cnt    <= '0;
      locked <= 1'b1;
    end else if (bsync_ratio == 16'd0) begin
      cnt <= '0;
    end else if (at_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 17'd1;
    end
  end

  // A well-aligned BSYNC edge coincides with the last count of the period. The
  // first edge after reset only establishes alignment, hence the locked gate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_err <= 1'b0;
    end else if (!misalign_check_en) begin
      misalign_err <= 1'b0;
    end else if (locked && bsync_captured && !at_wrap) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_adf4030_trig_channel.sv
// rtl/axi_adf4030_trig_channel.sv - one ADF4030 trigger output channel
//
// Purpose: arms on a rising trigger request, waits for a BSYNC edge, then fires a
//          PULSE_WIDTH-cycle pulse when the phase counter reaches the programmed phase.
// Ports:
//   clk               in   core clock
//   rstn              in   asynchronous active-low reset
//   channel_en        in   channel enable; low forces IDLE
//   phase             in   fire position within the BSYNC period
//   bsync_ratio       in   BSYNC half-period in clk cycles
//   bsync_captured    in   1-cycle pulse per captured BSYNC edge
//   trig_req          in   selected trigger source, level
//   misalign_check_en in   enable BSYNC misalignment check
//   trig_out          out  trigger pulse (registered)
//   trig_state        out  FSM state (registered)
//   misalign_err      out  sticky BSYNC misalignment flag
module axi_adf4030_trig_channel
  import axi_adf4030_pkg::*;
#(
  parameter int PULSE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    channel_en,
  input  logic [15:0]             phase,
  input  logic [15:0]             bsync_ratio,
  input  logic                    bsync_captured,
  input  logic                    trig_req,
  input  logic                    misalign_check_en,
  output logic                    trig_out,
  output logic [TRIG_STATE_W-1:0] trig_state,
  output logic                    misalign_err
);

  localparam logic [7:0] WIDTH_LAST = 8'(PULSE_WIDTH - 1);

  trig_state_t      state;
  trig_state_t      state_d;
  logic             req_q;
  logic             req_rise;
  logic [7:0]       wcnt;
  logic [7:0]       wcnt_d;
  logic             trig_out_q;
  logic             trig_out_d;
  logic [CNT_W-1:0] cnt;
  logic             ratio_nz;

  axi_adf4030_bsync_phase_cnt u_phase_cnt (
    .clk               (clk),
    .rstn              (rstn),
    .bsync_ratio       (bsync_ratio),
    .bsync_captured    (bsync_captured),
    .misalign_check_en (misalign_check_en),
    .cnt               (cnt),
    .misalign_err      (misalign_err)
  );

  assign ratio_nz = (bsync_ratio != 16'd0);
  assign req_rise = trig_req & ~req_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      wcnt       <= '0;
      trig_out_q <= 1'b0;
    end else begin
      state      <= state_d;
      req_q      <= trig_req;
      wcnt       <= wcnt_d;
      trig_out_q <= trig_out_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!channel_en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:       if (req_rise) state_d = ARMED;
        // The bsync edge is only consumed once ARMED has been entered, so an
        // edge coincident with the request rise is deliberately skipped.
        ARMED:      if (bsync_captured && ratio_nz) state_d = WAIT_PHASE;
        // A phase beyond the period never matches; the channel parks here.
        WAIT_PHASE: if (ratio_nz && (cnt == {1'b0, phase})) state_d = FIRE;
        FIRE:       if (wcnt == WIDTH_LAST) state_d = DONE;
        // Require a release of the request before the next arm.
        DONE:       if (!trig_req) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // trig_out follows the next state so the pulse is exactly the FIRE residency.
  always_comb begin
    trig_out_d = (state_d == FIRE);
    wcnt_d     = '0;
    if ((state == FIRE) && (state_d == FIRE)) begin
      wcnt_d = wcnt + 8'd1;
    end
  end

  assign trig_out   = trig_out_q;
  assign trig_state = state;

endmodule

// File: tb/tb_axi_adf4030_trig_channel.sv
// tb/tb_axi_adf4030_trig_channel.sv - directed self-checking bench for the trigger channel
module tb_axi_adf4030_trig_channel;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        channel_en = 1'b0;
  logic [15:0] phase = 16'd0;
  logic [15:0] bsync_ratio = 16'd0;
  logic        bsync_captured = 1'b0;
  logic        trig_req = 1'b0;
  logic        misalign_check_en = 1'b0;
  logic        trig_out;
  logic [2:0]  trig_state;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  axi_adf4030_trig_channel #(.PULSE_WIDTH(4)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .channel_en        (channel_en),
    .phase             (phase),
    .bsync_ratio       (bsync_ratio),
    .bsync_captured    (bsync_captured),
    .trig_req          (trig_req),
    .misalign_check_en (misalign_check_en),
    .trig_out          (trig_out),
    .trig_state        (trig_state),
    .misalign_err      (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bsync();
    bsync_captured = 1'b1;
    tick();
    bsync_captured = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL reset_trig_out: got %0b want 0", trig_out); end
    n_cmp++; if (trig_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", trig_state); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %0b want 0", misalign_err); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fire();
    channel_en = 1'b1; bsync_ratio = 16'd8; phase = 16'd5;
    trig_req = 1'b1;
    tick();
    n_cmp++; if (trig_state !== 3'd1) begin n_bad++; $display("FAIL fire_armed: got %0d want 1", trig_state); end
    pulse_bsync();
    n_cmp++; if (trig_state !== 3'd2) begin n_bad++; $display("FAIL fire_wait: got %0d want 2", trig_state); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 5) begin
        n_cmp++; if (trig_out !== 1'b0 || trig_state !== 3'd2) begin n_bad++; $display("FAIL fire_pre k=%0d: got out=%0b st=%0d want out=0 st=2", k, trig_out, trig_state); end
      end else if (k <= 9) begin
        n_cmp++; if (trig_out !== 1'b1 || trig_state !== 3'd3) begin n_bad++; $display("FAIL fire_high k=%0d: got out=%0b st=%0d want out=1 st=3", k, trig_out, trig_state); end
      end else begin
        n_cmp++; if (trig_out !== 1'b0 || trig_state !== 3'd4) begin n_bad++; $display("FAIL fire_done k=%0d: got out=%0b st=%0d want out=0 st=4", k, trig_out, trig_state); end
      end
    end
  endtask

  task automatic test_hold_release();
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++; if (trig_out !== 1'b0 || trig_state !== 3'd4) begin n_bad++; $display("FAIL hold k=%0d: got out=%0b st=%0d want out=0 st=4", k, trig_out, trig_state); end
    end
    trig_req = 1'b0;
    tick();
    n_cmp++; if (trig_state !== 3'd0) begin n_bad++; $display("FAIL release_idle: got %0d want 0", trig_state); end
    trig_req = 1'b1;
    tick();
    n_cmp++; if (trig_state !== 3'd1) begin n_bad++; $display("FAIL rearm: got %0d want 1", trig_state); end
  endtask

  task automatic test_disable_mid_fire();
    pulse_bsync();
    for (int k = 1; k <= 6; k++) tick();
    n_cmp++; if (trig_out !== 1'b1) begin n_bad++; $display("FAIL dis_first_high: got %0b want 1", trig_out); end
    tick();
    n_cmp++; if (trig_out !== 1'b1 || trig_state !== 3'd3) begin n_bad++; $display("FAIL dis_second_high: got out=%0b st=%0d want out=1 st=3", trig_out, trig_state); end
    channel_en = 1'b0;
    tick();
    n_cmp++; if (trig_out !== 1'b0 || trig_state !== 3'd0) begin n_bad++; $display("FAIL dis_abort: got out=%0b st=%0d want out=0 st=0", trig_out, trig_state); end
    channel_en = 1'b1;
    trig_req = 1'b0;
    tick();
    n_cmp++; if (trig_state !== 3'd0) begin n_bad++; $display("FAIL dis_stay_idle: got %0d want 0", trig_state); end
  endtask

  task automatic test_misalign();
    bsync_ratio = 16'd8;
    misalign_check_en = 1'b0;
    pulse_bsync();
    misalign_check_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 15; k++) tick();
      pulse_bsync();
      n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL misalign_aligned r=%0d: got %0b want 0", r, misalign_err); end
    end
    for (int k = 0; k < 9; k++) tick();
    pulse_bsync();
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL misalign_set: got %0b want 1", misalign_err); end
    for (int k = 0; k < 15; k++) tick();
    pulse_bsync();
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL misalign_sticky: got %0b want 1", misalign_err); end
    misalign_check_en = 1'b0;
    tick();
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL misalign_clear: got %0b want 0", misalign_err); end
  endtask

  task automatic test_ratio_zero_and_far_phase();
    bsync_ratio = 16'd0;
    trig_req = 1'b1;
    tick();
    n_cmp++; if (trig_state !== 3'd1) begin n_bad++; $display("FAIL r0_armed: got %0d want 1", trig_state); end
    for (int r = 0; r < 3; r++) begin
      pulse_bsync();
      n_cmp++; if (trig_state !== 3'd1 || trig_out !== 1'b0) begin n_bad++; $display("FAIL r0_stay r=%0d: got out=%0b st=%0d want out=0 st=1", r, trig_out, trig_state); end
      for (int k = 0; k < 5; k++) tick();
    end
    bsync_ratio = 16'd8;
    phase = 16'd20;
    pulse_bsync();
    n_cmp++; if (trig_state !== 3'd2) begin n_bad++; $display("FAIL far_wait: got %0d want 2", trig_state); end
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++; if (trig_state !== 3'd2 || trig_out !== 1'b0) begin n_bad++; $display("FAIL far_nofire k=%0d: got out=%0b st=%0d want out=0 st=2", k, trig_out, trig_state); end
    end
    channel_en = 1'b0;
    tick();
    n_cmp++; if (trig_state !== 3'd0) begin n_bad++; $display("FAIL far_disable: got %0d want 0", trig_state); end
    trig_req = 1'b0;
    channel_en = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    phase = 16'd5;
    bsync_ratio = 16'd8;
    trig_req = 1'b1;
    bsync_captured = 1'b1;
    tick();
    bsync_captured = 1'b0;
    n_cmp++; if (trig_state !== 3'd1) begin n_bad++; $display("FAIL sim_armed: got %0d want 1", trig_state); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (trig_state !== 3'd1) begin n_bad++; $display("FAIL sim_not_consumed k=%0d: got %0d want 1", k, trig_state); end
    end
    pulse_bsync();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        n_cmp++; if (trig_out !== 1'b0) begin n_bad++; $display("FAIL sim_early: got %0b want 0", trig_out); end
      end
    end
    n_cmp++; if (trig_out !== 1'b1) begin n_bad++; $display("FAIL sim_fire: got %0b want 1", trig_out); end
    trig_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_cmp++; if (trig_state !== 3'd0 || trig_out !== 1'b0) begin n_bad++; $display("FAIL sim_back_idle: got out=%0b st=%0d want out=0 st=0", trig_out, trig_state); end
  endtask

  task automatic test_async_reset();
    bsync_ratio = 16'd8;
    phase = 16'd20;
    misalign_check_en = 1'b1;
    trig_req = 1'b1;
    tick();
    pulse_bsync();
    for (int k = 0; k < 3; k++) tick();
    pulse_bsync();
    n_cmp++; if (trig_state !== 3'd2 || misalign_err !== 1'b1) begin n_bad++; $display("FAIL ar_pre_wait: got st=%0d err=%0b want st=2 err=1", trig_state, misalign_err); end
    rstn = 1'b0;
    #2;
    n_cmp++; if (trig_state !== 3'd0 || trig_out !== 1'b0 || misalign_err !== 1'b0) begin n_bad++; $display("FAIL ar_wait_reset: got st=%0d out=%0b err=%0b want 0 0 0", trig_state, trig_out, misalign_err); end
    misalign_check_en = 1'b0;
    trig_req = 1'b0;
    rstn = 1'b1;
    tick();
    phase = 16'd2;
    trig_req = 1'b1;
    tick();
    pulse_bsync();
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (trig_state !== 3'd3 || trig_out !== 1'b1) begin n_bad++; $display("FAIL ar_pre_fire: got st=%0d out=%0b want st=3 out=1", trig_state, trig_out); end
    rstn = 1'b0;
    #2;
    n_cmp++; if (trig_state !== 3'd0 || trig_out !== 1'b0) begin n_bad++; $display("FAIL ar_fire_reset: got st=%0d out=%0b want st=0 out=0", trig_state, trig_out); end
    trig_req = 1'b0;
    rstn = 1'b1;
    tick();
    n_cmp++; if (trig_state !== 3'd0 || trig_out !== 1'b0) begin n_bad++; $display("FAIL ar_after_release: got st=%0d out=%0b want st=0 out=0", trig_state, trig_out); end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_hold_release();
    test_disable_mid_fire();
    test_misalign();
    test_ratio_zero_and_far_phase();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
